blink_monitor: RTL and testbench

- Receiving end of the BLINK LED output: samples a blinking line, measures each half-period (cycles between toggles), and reports lock once the half-period is stable.
- Sits on the board/check side of a BLINK instance or any toggling status line.
- Flags irregular timing and a stuck line; re-acquires automatically after either.

---
 rtl/blink_monitor.sv | 89 ++++++++
 tb/tb_blink_monitor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/blink_monitor.sv
// blink_monitor: measures the half-period of a toggling line, reports lock, irregular and stuck errors.
// Define BLINK_MON_SYNC_EN to pass led_in through a 2-flop synchronizer first.
module blink_monitor #(
  parameter int CBITS = 17,
  parameter int TOL = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  output logic             edge_pls,
  output logic [CBITS+1:0] half_period,
  output logic             locked,
  output logic             irr_err,
  output logic             stuck_err
);
  localparam int W = CBITS + 2;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0] MAX = '1;
  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCK} state_t;
  state_t state;
  logic s, prev, edge_det, in_tol;
  logic [W-1:0] cnt, ref_q, diff;
  logic [MW-1:0] match;
`ifdef BLINK_MON_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s, sync_q} <= '0;
    else {s, sync_q} <= {sync_q, led_in};
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= 1'b0;
    else s <= led_in;
`endif
  assign edge_det = s ^ prev;
  assign diff = (cnt >= ref_q) ? cnt - ref_q : ref_q - cnt;
  assign in_tol = diff <= W'(TOL);
  assign half_period = ref_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prev <= 1'b0;
      edge_pls <= 1'b0;
      cnt <= '0;
      ref_q <= '0;
      match <= '0;
      locked <= 1'b0;
      irr_err <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      prev <= s;
      edge_pls <= edge_det;
      irr_err <= 1'b0;
      stuck_err <= 1'b0;
      // cnt==MAX without an edge outside IDLE is always a stuck event, so it restarts from 0
      cnt <= edge_det ? W'(1) : (state == IDLE || cnt == MAX) ? '0 : cnt + 1'b1;
      if (state != IDLE && !edge_det && cnt == MAX) begin
        stuck_err <= 1'b1;
        state <= IDLE;
        locked <= 1'b0;
        match <= '0;
      end else if (edge_det) begin
        case (state)
          IDLE: state <= ACQ;
          ACQ: begin
            ref_q <= cnt;
            match <= '0;
            state <= TRACK;
          end
          default: begin
            if (!in_tol) begin
              irr_err <= 1'b1;
              ref_q <= cnt;
              match <= '0;
              state <= TRACK;
              locked <= 1'b0;
            end else if (state == TRACK) begin
              match <= match + 1'b1;
              if (match == MW'(LOCK_CNT - 1)) begin
                state <= LOCK;
                locked <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed and random stimulus against a gap-based reference model of blink_monitor.
module tb_blink_monitor;
  localparam int CB = 2, TOL = 1, LC = 4, MAXC = 15;
`ifdef BLINK_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b0, led_in = 1'b0;
  logic edge_pls, locked, irr_err, stuck_err;
  logic [CB+1:0] half_period;
  int pass_n = 0, total_n = 0, irr_seen = 0, stuck_seen = 0, edge_seen = 0;
  bit h [1:5];
  int k = 0, t0 = 0, run = 0, m_ref = 0;
  bit seen = 0, have_ref = 0, m_locked = 0, m_edge = 0, m_irr = 0, m_stuck = 0;

  blink_monitor #(.CBITS(CB), .TOL(TOL), .LOCK_CNT(LC)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .edge_pls(edge_pls), .half_period(half_period),
    .locked(locked), .irr_err(irr_err), .stuck_err(stuck_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: an edge is a change in the sampled line LAT cycles back; each measured
  // half-period is the cycle gap between consecutive edges.
  task automatic model_step();
    int gap, meas, d;
    k++;
    m_edge = 0;
    m_irr = 0;
    m_stuck = 0;
    if (!rst) begin
      for (int i = 1; i <= 5; i++) h[i] = 0;
      seen = 0; have_ref = 0; m_locked = 0; run = 0; m_ref = 0; t0 = k;
      return;
    end
    m_edge = h[LAT] != h[LAT+1];
    gap = k - t0;
    if (m_edge) begin
      if (!seen) seen = 1;
      else begin
        meas = gap > MAXC ? MAXC : gap;
        d = meas > m_ref ? meas - m_ref : m_ref - meas;
        if (!have_ref) begin
          m_ref = meas; have_ref = 1; run = 0;
        end else if (d <= TOL) begin
          if (!m_locked) begin
            run++;
            if (run == LC) m_locked = 1;
          end
        end else begin
          m_irr = 1; m_ref = meas; run = 0; m_locked = 0;
        end
      end
      t0 = k;
    end else if (seen && gap >= MAXC) begin
      m_stuck = 1; seen = 0; have_ref = 0; run = 0; m_locked = 0;
    end
    for (int i = 5; i > 1; i--) h[i] = h[i-1];
    h[1] = led_in;
  endtask

  task automatic tick(input logic l, input logic r);
    @(posedge clk);
    model_step();
    #1;
    led_in = l;
    rst = r;
    @(negedge clk);
    check("edge_pls", edge_pls, rst ? int'(m_edge) : 0);
    check("locked", locked, rst ? int'(m_locked) : 0);
    check("irr_err", irr_err, rst ? int'(m_irr) : 0);
    check("stuck_err", stuck_err, rst ? int'(m_stuck) : 0);
    check("half_period", int'(half_period), rst ? m_ref : 0);
    irr_seen += int'(irr_err);
    stuck_seen += int'(stuck_err);
    edge_seen += int'(edge_pls);
  endtask

  task automatic half(input int n);
    for (int i = 0; i < n; i++) tick(i == 0 ? ~led_in : led_in, 1'b1);
  endtask

  initial begin
    for (int i = 1; i <= 5; i++) h[i] = 0;
    for (int i = 0; i < 3; i++) tick(~led_in, 1'b0);
    check("rst_edge", edge_pls, 0);
    check("rst_locked", locked, 0);
    check("rst_hp", int'(half_period), 0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    edge_seen = 0;
    half(4);
    check("first_edge_count", edge_seen, 1);
    check("first_locked", locked, 0);
    check("first_hp", int'(half_period), 0);
    for (int i = 0; i < 6; i++) half(4);
    check("lock_locked", locked, 1);
    check("lock_hp", int'(half_period), 4);
    check("lock_irr", irr_seen, 0);
    irr_seen = 0;
    half(5);
    for (int i = 0; i < 3; i++) half(4);
    check("tol_locked", locked, 1);
    check("tol_hp", int'(half_period), 4);
    check("tol_irr", irr_seen, 0);
    irr_seen = 0;
    half(7);
    half(4);
    check("irr_hp7", int'(half_period), 7);
    check("irr_unlocked", locked, 0);
    for (int i = 0; i < 6; i++) half(4);
    check("relock_irr", irr_seen, 2);
    check("relock_locked", locked, 1);
    check("relock_hp", int'(half_period), 4);
    stuck_seen = 0;
    for (int i = 0; i < 20; i++) tick(led_in, 1'b1);
    check("stuck_count", stuck_seen, 1);
    check("stuck_locked", locked, 0);
    check("stuck_hp", int'(half_period), 4);
    for (int i = 0; i < 7; i++) half(4);
    check("reacq_locked", locked, 1);
    tick(1'b0, 1'b0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_hp", int'(half_period), 0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) half(4);
    check("post_rst_not_yet", locked, 0);
    half(4);
    check("post_rst_locked", locked, 1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        for (int i = 0, m = int'($urandom_range(1, 3)); i < m; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
      end else half($urandom_range(0, 99) < 70 ? 4 : int'($urandom_range(1, 20)));
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
